exch_order_responder: RTL and testbench
=======================================

# exch_order_responder

Exchange-side responder for the trading datapath. It accepts the 178-bit trade orders produced by the trade decision logic, applies a per-order fill cap and inventory limit, and returns a 178-bit confirm message (MsgType 2'b11) after a programmable exchange latency. It closes the loop in simulation and on the demo fabric, and it tracks the net position held by the trading side.

## Interface
- LATENCY, 4: cycles between order acceptance and confirm valid; legal range 1..255.
- MAX_FILL, 8'd50: maximum quantity filled per order.
- clk_i  input  1  clock.
- reset_i  input  1  reset, asynchronous, active-high.
- order_i  input  178  order: [177:176] type, [175:144] Symbol, [143:80] sell price, [79:72] sell qty, [71:8] buy price, [7:0] buy qty.
- v_i  input  1  order valid.
- ready_o  output  1  responder can accept an order.
- confirm_o  output  178  confirm message; held stable while v_o=1.
- v_o  output  1  confirm valid.
- yumi_i  input  1  consumer takes confirm; only meaningful while v_o=1.
- position_o  output  16  net units held, unsigned.
- fills_o  output  16  confirms delivered, wraps.
- drops_o  output  16  orders accepted but dropped, wraps.

## Operation
- FSM states are IDLE, DELAY and SEND.
- ready_o = (state==IDLE). v_o = (state==SEND).
- Acceptance occurs on the edge where state==IDLE and v_i=1. At that edge, fill qty q is computed combinationally and registered:
  - Type 2'b01 (buy): q = min(order_i[7:0], MAX_FILL, 65535-position_r).
  - Type 2'b10 (sell): q = min(order_i[79:72], MAX_FILL, position_r[7:0] if position_r<256 else 255).
  - Type 2'b00 or 2'b11: q = 0.
- If q==0: the order is dropped. drops_o increments, state stays IDLE, and nothing is emitted. All-zero orders from the decision logic fall in this case.
- If q!=0: confirm_r is built and loaded with cnt=LATENCY-1, and state goes to DELAY.
  - Buy confirm: {2'b11, Symbol, 64'b0, 8'b0, order_i[71:8], q}.
  - Sell confirm: {2'b11, Symbol, order_i[143:80], q, 64'b0, 8'b0}.
- In DELAY: if cnt==0, go to SEND; else cnt decrements.
- In SEND: when v_o & yumi_i, go to IDLE, fills_o increments, and position updates (+q for buy, -q for sell).
- position_r never over- or underflows, by construction of q.
- confirm_o = confirm_r in all states. It is only meaningful while v_o=1.
- Only one order is outstanding at a time. v_i is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, so ready_o=1 and v_o=0.
  - confirm_o=0, position_o=0, fills_o=0, drops_o=0, cnt=0.
- Latency: an order accepted at edge E0 produces v_o=1 from edge E0+LATENCY onward.
- Throughput: at most one order per LATENCY+2 cycles, assuming yumi_i is asserted immediately.
- Dropped order: ready_o stays 1. A new order can be accepted on the very next edge.
- SEND with yumi_i=0: v_o and confirm_o hold indefinitely. Position does not change.
- yumi_i asserted while v_o=0: no effect.
- v_i high while not in IDLE: the order is not taken. The producer must hold it until ready_o=1.
- Counters wrap 65535→0.
- reset_i mid-DELAY or mid-SEND: state returns to IDLE asynchronously. The pending confirm is discarded, and position and the counters clear.
- LATENCY outside 1..255 is unsupported. An implementation may assert on it at elaboration.

## Test plan
- Reset then buy: reset, LATENCY=4, order type 01, Symbol 32'hAAPL, buy price 100, qty 20, accepted at E0.
  - v_o=1 at E0+4.
  - confirm_o[7:0]=20, confirm_o[71:8]=100, type 11.
  - After yumi, position_o=20 and fills_o=1.
- Fill cap and inventory: buy qty 80 → confirm qty 50, position 50. Then sell qty 200 at price 110 → confirm[79:72]=50, confirm[143:80]=110, position 0.
- Drops:
  - Sell qty 10 with position 0: dropped, drops_o=1, v_o never rises.
  - All-zero order: dropped, drops_o=2, ready_o stays 1 both cycles.
- Backpressure: hold yumi_i=0 for 10 cycles in SEND.
  - confirm_o is stable, position is unchanged, v_i is ignored.
  - Assert yumi_i: IDLE next edge, position updates once.
- Reset mid-operation: assert reset_i two cycles after acceptance. ready_o=1, v_o=0 and all counters 0 immediately. Afterwards a new order completes normally.
- Back-to-back: 3 buy orders of qty 5, with yumi_i tied high and LATENCY=1.
  - Acceptances spaced 3 cycles apart.
  - Final position_o=15, fills_o=3.

Source files
------------

// File: rtl/exch_order_responder.sv
// exch_order_responder: exchange-side responder that caps fills, enforces inventory
// limits and returns a confirm after a programmable latency.
module exch_order_responder #(
  parameter int          LATENCY  = 4,
  parameter logic [7:0]  MAX_FILL = 8'd50
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic [177:0] order_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [177:0] confirm_o,
  output logic         v_o,
  input  logic         yumi_i,
  output logic [15:0]  position_o,
  output logic [15:0]  fills_o,
  output logic [15:0]  drops_o
);
  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("LATENCY must be in 1..255");
  end
  typedef enum logic [1:0] {IDLE, DELAY, SEND} state_t;
  state_t       state_r;
  logic [7:0]   cnt_r;
  logic [177:0] confirm_r;
  logic [15:0]  position_r, fills_r, drops_r;
  logic [1:0]   typ;
  logic [7:0]   qty, cap, lim, q;
  logic [15:0]  room;
  logic         buy;
  // room is buy headroom or sell inventory; anything >= 256 cannot bind an 8-bit fill
  always_comb begin
    typ  = order_i[177:176];
    buy  = typ == 2'b01;
    qty  = buy ? order_i[7:0] : order_i[79:72];
    cap  = qty < MAX_FILL ? qty : MAX_FILL;
    room = buy ? 16'hffff - position_r : position_r;
    lim  = room < 16'd256 ? room[7:0] : 8'hff;
    q    = (typ[0] ^ typ[1]) ? (cap < lim ? cap : lim) : 8'd0;
  end
  assign ready_o    = state_r == IDLE;
  assign v_o        = state_r == SEND;
  assign confirm_o  = confirm_r;
  assign position_o = position_r;
  assign fills_o    = fills_r;
  assign drops_o    = drops_r;
  // only one of the two qty fields of a confirm is nonzero, so it encodes the position delta
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      confirm_r  <= '0;
      position_r <= '0;
      fills_r    <= '0;
      drops_r    <= '0;
    end else begin
      case (state_r)
        IDLE: if (v_i) begin
          if (q == 8'd0) drops_r <= drops_r + 16'd1;
          else begin
            confirm_r <= buy ? {2'b11, order_i[175:144], 64'b0, 8'b0, order_i[71:8], q}
                             : {2'b11, order_i[175:144], order_i[143:80], q, 64'b0, 8'b0};
            cnt_r     <= 8'(LATENCY - 1);
            state_r   <= DELAY;
          end
        end
        DELAY: if (cnt_r == 8'd0) state_r <= SEND;
               else cnt_r <= cnt_r - 8'd1;
        SEND: if (yumi_i) begin
          state_r    <= IDLE;
          fills_r    <= fills_r + 16'd1;
          position_r <= position_r + {8'b0, confirm_r[7:0]} - {8'b0, confirm_r[79:72]};
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exch_order_responder.sv
// tb_exch_order_responder: directed and randomized checks of the order responder
// against a min()-based position/counter model.
module tb_exch_order_responder;
  localparam int LAT = 4;
  localparam int MF  = 50;
  logic clk = 0, reset_i = 0;
  always #5 clk = ~clk;
  logic [177:0] order = '0, confirm;
  logic v_i = 0, yumi = 0, ready, v_o;
  logic [15:0] pos, fills, drops;
  logic [177:0] order1 = '0, confirm1;
  logic v1 = 0, ready1, v1_o;
  logic [15:0] pos1, fills1, drops1;
  int chk = 0, err = 0;
  int m_pos = 0, m_fills = 0, m_drops = 0;
  int cyc = 0;
  int acc[$];

  exch_order_responder #(.LATENCY(LAT), .MAX_FILL(8'(MF))) dut (
    .clk_i(clk), .reset_i(reset_i), .order_i(order), .v_i(v_i), .ready_o(ready),
    .confirm_o(confirm), .v_o(v_o), .yumi_i(yumi), .position_o(pos), .fills_o(fills), .drops_o(drops));
  exch_order_responder #(.LATENCY(1), .MAX_FILL(8'(MF))) dut1 (
    .clk_i(clk), .reset_i(reset_i), .order_i(order1), .v_i(v1), .ready_o(ready1),
    .confirm_o(confirm1), .v_o(v1_o), .yumi_i(1'b1), .position_o(pos1), .fills_o(fills1), .drops_o(drops1));

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ready1 && v1) acc.push_back(cyc);
  end

  function automatic logic [177:0] mk(input logic [1:0] t, input logic [31:0] sym, input logic [63:0] sp,
                                      input logic [7:0] sq, input logic [63:0] bp, input logic [7:0] bq);
    return {t, sym, sp, sq, bp, bq};
  endfunction

  function automatic int min3(input int a, input int b, input int c);
    int m;
    m = a < b ? a : b;
    return m < c ? m : c;
  endfunction

  function automatic int exp_q(input logic [177:0] o);
    if (o[177:176] == 2'b01) return min3(int'(o[7:0]), MF, 65535 - m_pos);
    if (o[177:176] == 2'b10) return min3(int'(o[79:72]), MF, m_pos < 256 ? m_pos : 255);
    return 0;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_i = 1;
    #1;
    if ({ready, v_o} !== 2'b10 || confirm !== '0 || pos !== 0 || fills !== 0 || drops !== 0) begin
      err++;
      $display("FAIL reset: ready=%b v_o=%b confirm=%h pos=%0d fills=%0d drops=%0d, want 1 0 0 0 0 0",
               ready, v_o, confirm, pos, fills, drops);
    end
    chk++;
    @(negedge clk);
    reset_i = 0;
    m_pos = 0; m_fills = 0; m_drops = 0;
  endtask

  task automatic do_order(input logic [177:0] o, input int hold);
    int q;
    logic [177:0] exp_c;
    @(negedge clk);
    if (ready !== 1'b1) begin err++; $display("FAIL pre_ready: got %b want 1", ready); end
    chk++;
    order = o; v_i = 1;
    @(posedge clk);
    q = exp_q(o);
    @(negedge clk);
    v_i = 0;
    if (q == 0) begin
      m_drops = (m_drops + 1) & 16'hffff;
      if (drops !== 16'(m_drops) || ready !== 1'b1 || v_o !== 1'b0) begin
        err++; $display("FAIL drop: drops=%0d ready=%b v_o=%b want %0d 1 0", drops, ready, v_o, m_drops);
      end
      chk++;
      return;
    end
    exp_c = o[177:176] == 2'b01 ? {2'b11, o[175:144], 64'b0, 8'b0, o[71:8], 8'(q)}
                                : {2'b11, o[175:144], o[143:80], 8'(q), 64'b0, 8'b0};
    for (int k = 0; k < LAT; k++) begin
      if (v_o !== 1'b0 || ready !== 1'b0) begin
        err++; $display("FAIL latency: cycle %0d v_o=%b ready=%b want 0 0", k, v_o, ready);
      end
      chk++;
      yumi = k[0];
      @(negedge clk);
    end
    yumi = 0;
    if (v_o !== 1'b1 || confirm !== exp_c) begin
      err++; $display("FAIL confirm: v_o=%b confirm=%h want 1 %h", v_o, confirm, exp_c);
    end
    chk++;
    for (int k = 0; k < hold; k++) begin
      v_i = 1; order = ~o;
      @(negedge clk);
      if (v_o !== 1'b1 || ready !== 1'b0 || confirm !== exp_c || pos !== 16'(m_pos)) begin
        err++; $display("FAIL hold: v_o=%b ready=%b confirm=%h pos=%0d want 1 0 %h %0d",
                        v_o, ready, confirm, pos, exp_c, m_pos);
      end
      chk++;
    end
    v_i = 0; yumi = 1;
    @(negedge clk);
    yumi = 0;
    m_pos = o[177:176] == 2'b01 ? m_pos + q : m_pos - q;
    m_fills = (m_fills + 1) & 16'hffff;
    if (v_o !== 1'b0 || ready !== 1'b1 || pos !== 16'(m_pos) || fills !== 16'(m_fills)) begin
      err++; $display("FAIL complete: v_o=%b ready=%b pos=%0d fills=%0d want 0 1 %0d %0d",
                      v_o, ready, pos, fills, m_pos, m_fills);
    end
    chk++;
  endtask

  task automatic test_reset();
    apply_reset();
  endtask

  task automatic test_buy();
    do_order(mk(2'b01, 32'h4141504C, 64'd0, 8'd0, 64'd100, 8'd20), 0);
    if (pos !== 16'd20 || fills !== 16'd1 || confirm[7:0] !== 8'd20 || confirm[71:8] !== 64'd100
        || confirm[177:176] !== 2'b11) begin
      err++; $display("FAIL buy: pos=%0d fills=%0d qty=%0d price=%0d type=%b want 20 1 20 100 11",
                      pos, fills, confirm[7:0], confirm[71:8], confirm[177:176]);
    end
    chk++;
  endtask

  task automatic test_fill_cap();
    apply_reset();
    do_order(mk(2'b01, 32'h4D534654, 64'd0, 8'd0, 64'd105, 8'd80), 0);
    if (pos !== 16'd50 || confirm[7:0] !== 8'd50) begin
      err++; $display("FAIL cap_buy: pos=%0d qty=%0d want 50 50", pos, confirm[7:0]);
    end
    chk++;
    do_order(mk(2'b10, 32'h4D534654, 64'd110, 8'd200, 64'd0, 8'd0), 0);
    if (pos !== 16'd0 || confirm[79:72] !== 8'd50 || confirm[143:80] !== 64'd110) begin
      err++; $display("FAIL cap_sell: pos=%0d qty=%0d price=%0d want 0 50 110", pos, confirm[79:72], confirm[143:80]);
    end
    chk++;
  endtask

  task automatic test_drops();
    @(negedge clk);
    order = mk(2'b10, 32'h474F4F47, 64'd90, 8'd10, 64'd0, 8'd0); v_i = 1;
    @(negedge clk);
    m_drops++;
    if (drops !== 16'(m_drops) || ready !== 1'b1 || v_o !== 1'b0) begin
      err++; $display("FAIL drop_sell: drops=%0d ready=%b v_o=%b want %0d 1 0", drops, ready, v_o, m_drops);
    end
    chk++;
    order = '0;
    @(negedge clk);
    v_i = 0;
    m_drops++;
    if (drops !== 16'(m_drops) || ready !== 1'b1 || v_o !== 1'b0) begin
      err++; $display("FAIL drop_zero: drops=%0d ready=%b v_o=%b want %0d 1 0", drops, ready, v_o, m_drops);
    end
    chk++;
  endtask

  task automatic test_backpressure();
    do_order(mk(2'b01, 32'h49424D20, 64'd0, 8'd0, 64'd77, 8'd30), 10);
    do_order(mk(2'b10, 32'h49424D20, 64'd88, 8'd12, 64'd0, 8'd0), 3);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    order = mk(2'b01, 32'h41424344, 64'd0, 8'd0, 64'd55, 8'd7); v_i = 1;
    @(negedge clk);
    v_i = 0;
    @(negedge clk);
    @(negedge clk);
    reset_i = 1;
    #1;
    if ({ready, v_o} !== 2'b10 || pos !== 0 || fills !== 0 || drops !== 0 || confirm !== '0) begin
      err++; $display("FAIL reset_mid: ready=%b v_o=%b pos=%0d fills=%0d drops=%0d want 1 0 0 0 0",
                      ready, v_o, pos, fills, drops);
    end
    chk++;
    @(negedge clk);
    reset_i = 0;
    m_pos = 0; m_fills = 0; m_drops = 0;
    do_order(mk(2'b01, 32'h41424344, 64'd0, 8'd0, 64'd56, 8'd9), 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      do_order(mk(2'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                  {$urandom, $urandom}, 8'($urandom)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    acc.delete();
    @(negedge clk);
    order1 = mk(2'b01, 32'h51515151, 64'd0, 8'd0, 64'd42, 8'd5); v1 = 1;
    for (int i = 0; i < 30 && acc.size() < 3; i++) @(negedge clk);
    v1 = 0;
    if (acc.size() != 3) begin
      err++; $display("FAIL b2b_count: got %0d acceptances want 3", acc.size());
    end else begin
      if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
        err++; $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc[1] - acc[0], acc[2] - acc[1]);
      end
    end
    chk++;
    repeat (4) @(negedge clk);
    if (pos1 !== 16'd15 || fills1 !== 16'd3 || v1_o !== 1'b0) begin
      err++; $display("FAIL b2b_final: pos=%0d fills=%0d v_o=%b want 15 3 0", pos1, fills1, v1_o);
    end
    chk++;
  endtask

  initial begin
    test_reset();
    test_buy();
    test_fill_cap();
    test_drops();
    test_backpressure();
    test_reset_mid();
    test_random();
    apply_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end
endmodule
